// File: rtl/fir_sample_writer.sv
// Write-side producer for the clk1/clk2 sample FIFO of the 64-tap FIR datapath.
// Upstream samples pass through a 2-entry skid buffer and are pushed into the FIFO in frames.
module fir_sample_writer #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = 7,
    parameter int STALL_W   = 16
) (
    input  logic               clk1,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               s_valid,
    input  logic [DATA_W-1:0]  s_data,
    output logic               s_ready,
    input  logic               fifo_full,
    output logic               fifo_w_en,
    output logic [DATA_W-1:0]  fifo_data,
    output logic               busy,
    output logic               frame_done,
    output logic [CNT_W-1:0]   push_cnt,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  buf_q [2];
    logic               wr_ptr_q, rd_ptr_q;
    logic [1:0]         count_q, count_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   push_cnt_q, push_cnt_d;
    logic [STALL_W-1:0] stall_cnt_q;
    logic               busy_q, frame_done_q;
    logic               active, accept, push, stalled;

    assign active     = (state_q == RUN) || (state_q == DRAIN);
    assign s_ready    = (state_q == RUN) && (in_cnt_q < FRAME_LEN_C) && (count_q != 2'd2);
    // Abort must never leak a write, even though it flushes the buffer at the next edge.
    assign fifo_w_en  = active && (count_q != 2'd0) && !fifo_full && !abort;
    assign fifo_data  = buf_q[rd_ptr_q];
    assign accept     = s_valid && s_ready;
    assign push       = fifo_w_en;
    assign stalled    = active && (count_q != 2'd0) && fifo_full;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign push_cnt   = push_cnt_q;
    assign stall_cnt  = stall_cnt_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q + 2'(accept) - 2'(push);
        in_cnt_d   = accept ? in_cnt_q + CNT_W'(1) : in_cnt_q;
        push_cnt_d = push ? push_cnt_q + CNT_W'(1) : push_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    in_cnt_d   = '0;
                    push_cnt_d = '0;
                end
            end
            RUN:     if (in_cnt_d == FRAME_LEN_C) state_d = DRAIN;
            DRAIN:   if ((push_cnt_d == FRAME_LEN_C) && (count_d == 2'd0)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d    = IDLE;
            count_d    = 2'd0;
            in_cnt_d   = '0;
            push_cnt_d = '0;
        end
    end

    // Flags are registered from the next state so they line up with state_q.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            in_cnt_q     <= '0;
            push_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            in_cnt_q     <= in_cnt_d;
            push_cnt_q   <= push_cnt_d;
            busy_q       <= (state_d == RUN) || (state_d == DRAIN);
            frame_done_q <= (state_d == DONE);
            if (abort) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (accept) begin
                    buf_q[wr_ptr_q] <= s_data;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (push) rd_ptr_q <= ~rd_ptr_q;
            end
            if (stalled && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_fir_sample_writer.sv
// Directed self-checking bench for fir_sample_writer: frames, backpressure, abort, reset, saturation.
module tb_fir_sample_writer;

    logic        clk1;
    logic        reset, start, abort, s_valid, fifo_full;
    logic [15:0] s_data;
    logic        s_ready, fifo_w_en, busy, frame_done;
    logic [15:0] fifo_data;
    logic [6:0]  push_cnt;
    logic [15:0] stall_cnt;

    logic        reset4, start4, abort4, sValid4, fifoFull4;
    logic [15:0] sData4;
    logic        sReady4, fifoWEn4, busy4, frameDone4;
    logic [15:0] fifoData4;
    logic [6:0]  pushCnt4;
    logic [3:0]  stallCnt4;

    int vectors = 0;
    int miscompares = 0;

    int pushCount, firstPush, lastPush, firstAccept, doneCycle;
    int readyLow, wenWhileFull, minSpace, maxSpace;
    bit doneSeen;

    fir_sample_writer dut (
        .clk1(clk1), .reset(reset), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .fifo_full(fifo_full), .fifo_w_en(fifo_w_en), .fifo_data(fifo_data),
        .busy(busy), .frame_done(frame_done), .push_cnt(push_cnt), .stall_cnt(stall_cnt)
    );

    fir_sample_writer #(.STALL_W(4)) dut4 (
        .clk1(clk1), .reset(reset4), .start(start4), .abort(abort4),
        .s_valid(sValid4), .s_data(sData4), .s_ready(sReady4),
        .fifo_full(fifoFull4), .fifo_w_en(fifoWEn4), .fifo_data(fifoData4),
        .busy(busy4), .frame_done(frameDone4), .push_cnt(pushCnt4), .stall_cnt(stallCnt4)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not terminate");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // mode 0: never full; 1: full for 5 cycles after first push; 2: depth-1 FIFO model; 3: full once 19 accepted
    task automatic applyStimulus(input logic [15:0] base, input int mode, input int stopAccepts, input int maxCycles);
        int  sent;
        int  timer;
        bit  trig;
        bit  accepted;
        bit  pushedNow;
        sent = 0; timer = 0; trig = 1'b0;
        pushCount = 0; firstPush = -1; lastPush = -1; firstAccept = -1; doneCycle = -1;
        readyLow = 0; wenWhileFull = 0; minSpace = 1000; maxSpace = 0; doneSeen = 1'b0;
        fifo_full = 1'b0;
        for (int cyc = 0; cyc < maxCycles; cyc++) begin
            s_valid = (sent < 64) && !((stopAccepts > 0) && (sent >= stopAccepts));
            s_data  = 16'(base + 16'(sent));
            @(negedge clk1);
            accepted  = s_valid && s_ready;
            pushedNow = fifo_w_en;
            if (accepted && firstAccept < 0) firstAccept = cyc;
            if (s_valid && !s_ready) readyLow++;
            if (fifo_w_en) begin
                if (fifo_full) wenWhileFull++;
                checkOutput("pushData", 32'(fifo_data), 32'(16'(base + 16'(pushCount))));
                if (lastPush >= 0) begin
                    if (cyc - lastPush < minSpace) minSpace = cyc - lastPush;
                    if (cyc - lastPush > maxSpace) maxSpace = cyc - lastPush;
                end
                if (firstPush < 0) firstPush = cyc;
                lastPush = cyc;
                pushCount++;
            end
            if (frame_done) begin
                doneSeen  = 1'b1;
                doneCycle = cyc;
                checkOutput("donePushCnt", 32'(push_cnt), 64);
                checkOutput("doneBusy", 32'(busy), 0);
            end
            step();
            if (accepted) sent++;
            case (mode)
                1: begin
                    if (pushedNow && !trig) begin
                        trig = 1'b1; fifo_full = 1'b1; timer = 5;
                    end else if (timer > 0) begin
                        timer--;
                        if (timer == 0) fifo_full = 1'b0;
                    end
                end
                2: begin
                    if (pushedNow) begin
                        fifo_full = 1'b1; timer = 3;
                    end else if (timer > 0) begin
                        timer--;
                        if (timer == 0) fifo_full = 1'b0;
                    end
                end
                3: fifo_full = (sent >= 19);
                default: fifo_full = 1'b0;
            endcase
            if (doneSeen) break;
            if ((stopAccepts > 0) && (sent >= stopAccepts)) break;
        end
        s_valid = 1'b0;
        if (stopAccepts == 0) checkOutput("frameTimeout", 32'(doneSeen), 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0; fifo_full = 1'b0;
        reset4 = 1'b1; start4 = 1'b0; abort4 = 1'b0; sValid4 = 1'b0; sData4 = '0; fifoFull4 = 1'b0;

        // Reset state of both instances
        #12;
        checkOutput("rstReady", 32'(s_ready), 0);
        checkOutput("rstWEn", 32'(fifo_w_en), 0);
        checkOutput("rstData", 32'(fifo_data), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstDone", 32'(frame_done), 0);
        checkOutput("rstPushCnt", 32'(push_cnt), 0);
        checkOutput("rstStall", 32'(stall_cnt), 0);
        checkOutput("rst4Outs", {sReady4, fifoWEn4, busy4, frameDone4, fifoData4, 5'd0, pushCnt4}, 0);
        checkOutput("rst4Stall", 32'(stallCnt4), 0);
        step();
        reset = 1'b0;

        // Basic frame at full throughput
        pulseStart();
        checkOutput("basicBusy", 32'(busy), 1);
        applyStimulus(16'h0001, 0, 0, 200);
        checkOutput("basicPushes", pushCount, 64);
        checkOutput("basicLatency", firstPush, firstAccept + 1);
        checkOutput("basicSpan", lastPush - firstPush, 63);
        checkOutput("basicMaxSpace", maxSpace, 1);
        checkOutput("basicDoneCyc", doneCycle, lastPush + 1);
        checkOutput("basicStall", 32'(stall_cnt), 0);
        checkOutput("basicIdle", 32'(busy), 0);
        checkOutput("basicDonePulse", 32'(frame_done), 0);

        // Backpressure: five full cycles right after the first push
        reset = 1'b1; step(); reset = 1'b0;
        pulseStart();
        applyStimulus(16'h1000, 1, 0, 300);
        checkOutput("bpPushes", pushCount, 64);
        checkOutput("bpStall", 32'(stall_cnt), 5);
        checkOutput("bpReadyLow", readyLow, 5);
        checkOutput("bpWEnFull", wenWhileFull, 0);
        checkOutput("bpLastPush", lastPush, 69);
        checkOutput("bpDoneCyc", doneCycle, 70);

        // Abort with 20 accepted, 18 pushed and 2 buffered
        pulseStart();
        applyStimulus(16'h2000, 3, 20, 100);
        checkOutput("abPushed", pushCount, 18);
        fifo_full = 1'b0;
        abort = 1'b1;
        @(negedge clk1);
        checkOutput("abWEn", 32'(fifo_w_en), 0);
        step();
        abort = 1'b0;
        checkOutput("abBusy", 32'(busy), 0);
        checkOutput("abPushCnt", 32'(push_cnt), 0);
        checkOutput("abReady", 32'(s_ready), 0);
        checkOutput("abDone", 32'(frame_done), 0);
        checkOutput("abStall", 32'(stall_cnt), 6);
        step();
        checkOutput("abDoneLater", 32'(frame_done), 0);
        pulseStart();
        applyStimulus(16'h2100, 0, 0, 200);
        checkOutput("abNextPushes", pushCount, 64);
        checkOutput("abNextSpan", lastPush - firstPush, 63);

        // start during RUN is ignored, start with abort in IDLE stays IDLE
        pulseStart();
        applyStimulus(16'h3000, 0, 10, 50);
        checkOutput("igPushed", pushCount, 9);
        pulseStart();
        checkOutput("igPushCnt", 32'(push_cnt), 10);
        checkOutput("igBusy", 32'(busy), 1);
        checkOutput("igReady", 32'(s_ready), 1);
        abort = 1'b1; step(); abort = 1'b0;
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        checkOutput("saBusy", 32'(busy), 0);
        checkOutput("saReady", 32'(s_ready), 0);
        step();
        checkOutput("saBusyLater", 32'(busy), 0);

        // Asynchronous reset in the middle of a frame
        pulseStart();
        applyStimulus(16'h4000, 0, 10, 50);
        s_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        checkOutput("arBusy", 32'(busy), 0);
        checkOutput("arPushCnt", 32'(push_cnt), 0);
        checkOutput("arReady", 32'(s_ready), 0);
        checkOutput("arWEn", 32'(fifo_w_en), 0);
        checkOutput("arData", 32'(fifo_data), 0);
        checkOutput("arStall", 32'(stall_cnt), 0);
        s_valid = 1'b0;
        step();
        reset = 1'b0;

        // Depth-1 FIFO behaviour: full for three cycles after each write
        pulseStart();
        applyStimulus(16'hA000, 2, 0, 400);
        checkOutput("d1Pushes", pushCount, 64);
        checkOutput("d1MinSpace", minSpace, 4);
        checkOutput("d1MaxSpace", maxSpace, 4);
        checkOutput("d1LastPush", lastPush, 253);
        checkOutput("d1WEnFull", wenWhileFull, 0);

        // Stall counter saturation on the 4-bit instance
        reset4 = 1'b0;
        start4 = 1'b1; step(); start4 = 1'b0;
        sValid4 = 1'b1; sData4 = 16'h5555; fifoFull4 = 1'b1;
        repeat (4) step();
        checkOutput("satMid", 32'(stallCnt4), 3);
        checkOutput("satWEn", 32'(fifoWEn4), 0);
        repeat (20) step();
        checkOutput("satTop", 32'(stallCnt4), 32'hF);
        checkOutput("satBusy", 32'(busy4), 1);
        #2 reset4 = 1'b1;
        #1;
        checkOutput("satRst", 32'(stallCnt4), 0);
        checkOutput("satRstBusy", 32'(busy4), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
